// File: rtl/selfu_rs.sv
// Reservation station for the select functional unit: buffers dispatched ops, captures
// CDB results for waiting sources and issues the oldest fully-ready entry to the FU.
module selfu_rs #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                disp_valid_i,
  output logic                disp_ready_o,
  input  logic [DATA_W-1:0]   disp_operand_i,
  input  logic [7:0]          disp_flags_i,
  input  logic [7:0]          disp_wbs_i,
  input  logic [TAG_W-1:0]    disp_robid_i,
  input  logic [1:0]          disp_rdy_i,
  input  logic [2*TAG_W-1:0]  disp_tag_i,
  input  logic [2*DATA_W-1:0] disp_val_i,
  input  logic                cdb_valid_i,
  input  logic [TAG_W-1:0]    cdb_id_i,
  input  logic [DATA_W-1:0]   cdb_val_i,
  input  logic                flush_i,
  input  logic                fu_busy_i,
  output logic                issue_transmit_o,
  output logic [DATA_W-1:0]   issue_operand_o,
  output logic [2*DATA_W-1:0] issue_depvals_o,
  output logic [7:0]          issue_wbs_o,
  output logic [7:0]          issue_flags_o,
  output logic [TAG_W-1:0]    issue_robid_o,
  output logic [3:0]          occupancy_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Age is a dense rank among valid entries: 0 is the oldest.
  localparam int unsigned AgeW = IdxW;

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [1:0]         rdy_q   [DEPTH];
  logic [1:0]         rdy_d   [DEPTH];
  logic [2*TAG_W-1:0] tag_q   [DEPTH];
  logic [2*TAG_W-1:0] tag_d   [DEPTH];
  logic [2*DATA_W-1:0] val_q  [DEPTH];
  logic [2*DATA_W-1:0] val_d  [DEPTH];
  logic [DATA_W-1:0]  opnd_q  [DEPTH];
  logic [DATA_W-1:0]  opnd_d  [DEPTH];
  logic [7:0]         flags_q [DEPTH];
  logic [7:0]         flags_d [DEPTH];
  logic [7:0]         wbs_q   [DEPTH];
  logic [7:0]         wbs_d   [DEPTH];
  logic [TAG_W-1:0]   robid_q [DEPTH];
  logic [TAG_W-1:0]   robid_d [DEPTH];
  logic [AgeW-1:0]    age_q   [DEPTH];
  logic [AgeW-1:0]    age_d   [DEPTH];
  logic [3:0]         occ_q, occ_d;

  logic                transmit_q;
  logic [DATA_W-1:0]   iss_opnd_q;
  logic [2*DATA_W-1:0] iss_val_q;
  logic [7:0]          iss_wbs_q;
  logic [7:0]          iss_flags_q;
  logic [TAG_W-1:0]    iss_robid_q;

  logic            sel_found, free_found, issue_fire, disp_fire;
  logic [IdxW-1:0] sel_idx, free_idx;
  logic [AgeW-1:0] sel_age;
  logic [1:0]      src_rdy;
  logic [3:0]      new_age;

  assign disp_ready_o = !flush_i && (occ_q < 4'(DEPTH));
  assign disp_fire    = disp_valid_i && disp_ready_o;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (&rdy_q[i]) && (!sel_found || age_q[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        sel_age   = age_q[i];
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign issue_fire = sel_found && !fu_busy_i && !flush_i;
  // Src1 counts as ready when it is an immediate.
  assign src_rdy    = disp_rdy_i | {disp_flags_i[1], 1'b0};
  assign new_age    = occ_q - 4'(issue_fire);

  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    tag_d   = tag_q;
    val_d   = val_q;
    opnd_d  = opnd_q;
    flags_d = flags_q;
    wbs_d   = wbs_q;
    robid_d = robid_q;
    age_d   = age_q;
    occ_d   = occ_q + 4'(disp_fire) - 4'(issue_fire);

    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (valid_q[i] && !rdy_q[i][s] && cdb_valid_i &&
            tag_q[i][s*TAG_W +: TAG_W] == cdb_id_i) begin
          rdy_d[i][s]                  = 1'b1;
          val_d[i][s*DATA_W +: DATA_W] = cdb_val_i;
        end
      end
      if (issue_fire && valid_q[i] && age_q[i] > sel_age) begin
        age_d[i] = age_q[i] - AgeW'(1);
      end
    end

    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
    end

    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      tag_d[free_idx]   = disp_tag_i;
      val_d[free_idx]   = disp_val_i;
      opnd_d[free_idx]  = disp_operand_i;
      flags_d[free_idx] = disp_flags_i;
      wbs_d[free_idx]   = disp_wbs_i;
      robid_d[free_idx] = disp_robid_i;
      age_d[free_idx]   = new_age[AgeW-1:0];
      rdy_d[free_idx]   = src_rdy;
      for (int s = 0; s < 2; s++) begin
        if (!src_rdy[s] && cdb_valid_i && disp_tag_i[s*TAG_W +: TAG_W] == cdb_id_i) begin
          rdy_d[free_idx][s]                  = 1'b1;
          val_d[free_idx][s*DATA_W +: DATA_W] = cdb_val_i;
        end
      end
    end

    if (flush_i) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      occ_q       <= '0;
      transmit_q  <= 1'b0;
      iss_opnd_q  <= '0;
      iss_val_q   <= '0;
      iss_wbs_q   <= '0;
      iss_flags_q <= '0;
      iss_robid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdy_q[i]   <= '0;
        tag_q[i]   <= '0;
        val_q[i]   <= '0;
        opnd_q[i]  <= '0;
        flags_q[i] <= '0;
        wbs_q[i]   <= '0;
        robid_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      transmit_q <= issue_fire;
      if (issue_fire) begin
        iss_opnd_q  <= opnd_q[sel_idx];
        iss_val_q   <= val_q[sel_idx];
        iss_wbs_q   <= wbs_q[sel_idx];
        iss_flags_q <= flags_q[sel_idx];
        iss_robid_q <= robid_q[sel_idx];
      end
      for (int i = 0; i < DEPTH; i++) begin
        rdy_q[i]   <= rdy_d[i];
        tag_q[i]   <= tag_d[i];
        val_q[i]   <= val_d[i];
        opnd_q[i]  <= opnd_d[i];
        flags_q[i] <= flags_d[i];
        wbs_q[i]   <= wbs_d[i];
        robid_q[i] <= robid_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  assign issue_transmit_o = transmit_q;
  assign issue_operand_o  = iss_opnd_q;
  assign issue_depvals_o  = iss_val_q;
  assign issue_wbs_o      = iss_wbs_q;
  assign issue_flags_o    = iss_flags_q;
  assign issue_robid_o    = iss_robid_q;
  assign occupancy_o      = occ_q;

endmodule

// File: tb/tb_selfu_rs.sv
// Directed bench for selfu_rs: dispatch, wakeup, bypass, age order, fu_busy, flush and reset.
module tb_selfu_rs;

  logic        clk = 1'b0;
  logic        rst, disp_valid, disp_ready;
  logic [7:0]  disp_operand, disp_flags, disp_wbs;
  logic [3:0]  disp_robid;
  logic [1:0]  disp_rdy;
  logic [7:0]  disp_tag;
  logic [15:0] disp_val;
  logic        cdb_valid;
  logic [3:0]  cdb_id;
  logic [7:0]  cdb_val;
  logic        flush, fu_busy;
  logic        issue_transmit;
  logic [7:0]  issue_operand;
  logic [15:0] issue_depvals;
  logic [7:0]  issue_wbs, issue_flags;
  logic [3:0]  issue_robid;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  selfu_rs #(.DEPTH(4), .TAG_W(4), .DATA_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .disp_valid_i    (disp_valid),
    .disp_ready_o    (disp_ready),
    .disp_operand_i  (disp_operand),
    .disp_flags_i    (disp_flags),
    .disp_wbs_i      (disp_wbs),
    .disp_robid_i    (disp_robid),
    .disp_rdy_i      (disp_rdy),
    .disp_tag_i      (disp_tag),
    .disp_val_i      (disp_val),
    .cdb_valid_i     (cdb_valid),
    .cdb_id_i        (cdb_id),
    .cdb_val_i       (cdb_val),
    .flush_i         (flush),
    .fu_busy_i       (fu_busy),
    .issue_transmit_o(issue_transmit),
    .issue_operand_o (issue_operand),
    .issue_depvals_o (issue_depvals),
    .issue_wbs_o     (issue_wbs),
    .issue_flags_o   (issue_flags),
    .issue_robid_o   (issue_robid),
    .occupancy_o     (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] robid, input logic [1:0] rdy, input logic [7:0] tag,
                      input logic [15:0] val, input logic [7:0] flags);
    disp_valid   = 1'b1;
    disp_robid   = robid;
    disp_rdy     = rdy;
    disp_tag     = tag;
    disp_val     = val;
    disp_flags   = flags;
    disp_operand = {4'h5, robid};
    disp_wbs     = {4'hA, robid};
  endtask

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_operand = '0; disp_flags = '0; disp_wbs = '0;
    disp_robid = '0; disp_rdy = '0; disp_tag = '0; disp_val = '0;
    cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0; flush = 1'b0; fu_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_transmit", 32'(issue_transmit), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_depvals", 32'(issue_depvals), 0);
    chk("rst_robid", 32'(issue_robid), 0);

    // 1: both sources ready, issues the cycle after dispatch
    disp(4'd3, 2'b11, 8'h00, 16'h2211, 8'h00);
    tick();
    disp_valid = 1'b0;
    chk("t1_occ1", 32'(occupancy), 1);
    chk("t1_tx0", 32'(issue_transmit), 0);
    tick();
    chk("t1_tx", 32'(issue_transmit), 1);
    chk("t1_dep", 32'(issue_depvals), 32'h2211);
    chk("t1_robid", 32'(issue_robid), 3);
    chk("t1_opnd", 32'(issue_operand), 32'h53);
    chk("t1_wbs", 32'(issue_wbs), 32'hA3);
    chk("t1_occ0", 32'(occupancy), 0);
    tick();
    chk("t1_tx_drop", 32'(issue_transmit), 0);
    chk("t1_dep_hold", 32'(issue_depvals), 32'h2211);

    // 2: src0 waits on tag 5; a non-matching broadcast is ignored
    disp(4'd4, 2'b10, 8'h05, 16'h7700, 8'h00);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_id = 4'd6; cdb_val = 8'hEE;
    tick();
    cdb_valid = 1'b0;
    chk("t2_wait", 32'(issue_transmit), 0);
    cdb_valid = 1'b1; cdb_id = 4'd5; cdb_val = 8'hA5;
    tick();
    cdb_valid = 1'b0;
    chk("t2_notyet", 32'(issue_transmit), 0);
    tick();
    chk("t2_tx", 32'(issue_transmit), 1);
    chk("t2_dep", 32'(issue_depvals), 32'h77A5);
    chk("t2_robid", 32'(issue_robid), 4);

    // 3: same-cycle bypass at dispatch
    disp(4'd6, 2'b10, 8'h07, 16'h0100, 8'h00);
    cdb_valid = 1'b1; cdb_id = 4'd7; cdb_val = 8'h3C;
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    chk("t3_tx0", 32'(issue_transmit), 0);
    tick();
    chk("t3_tx", 32'(issue_transmit), 1);
    chk("t3_dep", 32'(issue_depvals), 32'h013C);
    chk("t3_robid", 32'(issue_robid), 6);

    // 4: fill while busy; then age order must survive a freed slot being reused
    fu_busy = 1'b1;
    for (int r = 8; r < 12; r++) begin
      disp(4'(r), 2'b11, 8'h00, {8'h80, 8'(r)}, 8'h00);
      tick();
    end
    disp_valid = 1'b0;
    #1;
    chk("t4_occ4", 32'(occupancy), 4);
    chk("t4_full", 32'(disp_ready), 0);
    chk("t4_busy_tx", 32'(issue_transmit), 0);
    disp(4'd13, 2'b11, 8'h00, 16'h0000, 8'h00);
    tick();
    disp_valid = 1'b0;
    chk("t4_reject", 32'(occupancy), 4);
    fu_busy = 1'b0;
    #1;
    chk("t4_full_issue", 32'(disp_ready), 0);
    tick();
    chk("t4_first", 32'(issue_robid), 8);
    chk("t4_first_tx", 32'(issue_transmit), 1);
    chk("t4_occ3", 32'(occupancy), 3);
    fu_busy = 1'b1;
    disp(4'd12, 2'b11, 8'h00, 16'h0000, 8'h00);
    tick();
    disp_valid = 1'b0;
    fu_busy = 1'b0;
    chk("t4_refill", 32'(occupancy), 4);
    chk("t4_busy_hold", 32'(issue_transmit), 0);
    for (int r = 9; r < 13; r++) begin
      tick();
      chk($sformatf("t4_order_%0d", r), 32'({issue_transmit, issue_robid}), 32'(16 + r));
    end
    chk("t4_empty", 32'(occupancy), 0);
    tick();
    chk("t4_idle", 32'(issue_transmit), 0);

    // 5: younger entry woken first issues first
    disp(4'd1, 2'b10, 8'h02, 16'h1000, 8'h00);
    tick();
    disp(4'd2, 2'b10, 8'h01, 16'h2000, 8'h00);
    tick();
    disp_valid = 1'b0;
    chk("t5_occ2", 32'(occupancy), 2);
    cdb_valid = 1'b1; cdb_id = 4'd1; cdb_val = 8'hB1;
    tick();
    cdb_id = 4'd2; cdb_val = 8'hB2;
    chk("t5_none", 32'(issue_transmit), 0);
    tick();
    cdb_valid = 1'b0;
    chk("t5_young", 32'({issue_transmit, issue_robid}), 32'h12);
    chk("t5_young_dep", 32'(issue_depvals), 32'h20B1);
    tick();
    chk("t5_old", 32'({issue_transmit, issue_robid}), 32'h11);
    chk("t5_old_dep", 32'(issue_depvals), 32'h10B2);
    // Immediate src1: disp_rdy[1]=0 must not stall it
    disp(4'd5, 2'b01, 8'h90, 16'h3344, 8'h02);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("t5_imm", 32'({issue_transmit, issue_robid}), 32'h15);
    chk("t5_imm_dep", 32'(issue_depvals), 32'h3344);
    chk("t5_imm_flags", 32'(issue_flags), 32'h02);

    // 6: flush drops everything including the same-cycle dispatch
    fu_busy = 1'b1;
    for (int r = 12; r < 15; r++) begin
      disp(4'(r), 2'b11, 8'h00, 16'h0000, 8'h00);
      tick();
    end
    chk("t6_occ3", 32'(occupancy), 3);
    disp(4'd15, 2'b11, 8'h00, 16'h0000, 8'h00);
    flush = 1'b1;
    fu_busy = 1'b0;
    #1;
    chk("t6_flush_ready", 32'(disp_ready), 0);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk("t6_occ0", 32'(occupancy), 0);
    chk("t6_tx0", 32'(issue_transmit), 0);
    tick();
    chk("t6_no_issue_a", 32'(issue_transmit), 0);
    tick();
    chk("t6_no_issue_b", 32'(issue_transmit), 0);
    chk("t6_hold_robid", 32'(issue_robid), 5);

    // Reset mid-operation clears the issue bundle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_robid", 32'(issue_robid), 0);
    chk("rst2_dep", 32'(issue_depvals), 0);
    chk("rst2_flags", 32'(issue_flags), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
